// File: rtl/frame_builder_if.sv
// Block-stream bundle between the frame builder, its upstream data generator
// and the downstream PCS path.
interface frame_builder_if #(
    parameter int DATA_BLOCK_LEN  = 64,
    parameter int SYNC_LEN        = 2,
    parameter int FRAME_CNT_WIDTH = 16
);
    logic [DATA_BLOCK_LEN-1:0]          i_data_block;
    logic                               o_data_req;
    logic [SYNC_LEN+DATA_BLOCK_LEN-1:0] o_block;
    logic                               o_valid;
    logic [FRAME_CNT_WIDTH-1:0]         o_frame_cnt;

    modport master (
        input  i_data_block,
        output o_data_req,
        output o_block,
        output o_valid,
        output o_frame_cnt
    );

    modport slave (
        output i_data_block,
        input  o_data_req,
        input  o_block,
        input  o_valid,
        input  o_frame_cnt
    );
endinterface

// File: rtl/frame_builder.sv
// Emits a continuous 64b/66b test stream of repeating frames:
// idles, START, N data blocks from the generator, TERM.
module frame_builder #(
    parameter int DATA_BLOCK_LEN  = 64,
    parameter int SYNC_LEN        = 2,
    parameter int LEN_WIDTH       = 16,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [LEN_WIDTH-1:0] i_data_len,
    input  logic [LEN_WIDTH-1:0] i_idle_len,
    frame_builder_if.master      bus
);
    localparam int BLOCK_W = SYNC_LEN + DATA_BLOCK_LEN;

    localparam logic [SYNC_LEN-1:0]       SYNC_CTRL     = 2'b10;
    localparam logic [SYNC_LEN-1:0]       SYNC_DATA     = 2'b01;
    localparam logic [DATA_BLOCK_LEN-1:0] PAYLOAD_IDLE  = 64'h1E00_0000_0000_0000;
    localparam logic [DATA_BLOCK_LEN-1:0] PAYLOAD_START = 64'h7855_5555_5555_55D5;
    localparam logic [DATA_BLOCK_LEN-1:0] PAYLOAD_TERM  = 64'h8700_0000_0000_0000;
    localparam logic [BLOCK_W-1:0]        BLOCK_IDLE    = {SYNC_CTRL, PAYLOAD_IDLE};
    localparam logic [BLOCK_W-1:0]        BLOCK_START   = {SYNC_CTRL, PAYLOAD_START};
    localparam logic [BLOCK_W-1:0]        BLOCK_TERM    = {SYNC_CTRL, PAYLOAD_TERM};

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_TERM
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [LEN_WIDTH-1:0]       r_cnt;
    logic [LEN_WIDTH-1:0]       w_cnt_next;
    logic [LEN_WIDTH-1:0]       r_idle_len_q;
    logic [LEN_WIDTH-1:0]       w_idle_len_next;
    logic [LEN_WIDTH-1:0]       r_data_len_q;
    logic [LEN_WIDTH-1:0]       w_data_len_next;
    logic [LEN_WIDTH:0]         w_cnt_inc;
    logic [BLOCK_W-1:0]         r_block;
    logic [BLOCK_W-1:0]         w_block_next;
    logic                       r_valid;
    logic [FRAME_CNT_WIDTH-1:0] r_frame_cnt;
    logic [FRAME_CNT_WIDTH-1:0] w_frame_cnt_next;

    // One bit wider so a counter at all-ones still compares correctly.
    assign w_cnt_inc = {1'b0, r_cnt} + {{LEN_WIDTH{1'b0}}, 1'b1};

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_idle_len_next  = r_idle_len_q;
        w_data_len_next  = r_data_len_q;
        w_frame_cnt_next = r_frame_cnt;
        w_block_next     = BLOCK_IDLE;
        case (r_state)
            S_IDLE: begin
                w_block_next = BLOCK_IDLE;
                w_cnt_next   = w_cnt_inc[LEN_WIDTH-1:0];
                if (w_cnt_inc >= {1'b0, r_idle_len_q}) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_block_next    = BLOCK_START;
                w_data_len_next = i_data_len;
                w_cnt_next      = '0;
                w_state_next    = (i_data_len == '0) ? S_TERM : S_DATA;
            end
            S_DATA: begin
                w_block_next = {SYNC_DATA, bus.i_data_block};
                w_cnt_next   = w_cnt_inc[LEN_WIDTH-1:0];
                if (r_cnt == r_data_len_q - LEN_WIDTH'(1)) begin
                    w_state_next = S_TERM;
                end
            end
            S_TERM: begin
                w_block_next     = BLOCK_TERM;
                w_idle_len_next  = i_idle_len;
                w_cnt_next       = '0;
                w_frame_cnt_next = r_frame_cnt + FRAME_CNT_WIDTH'(1);
                w_state_next     = (i_idle_len == '0) ? S_START : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Reset samples the idle length so the first gap honours it immediately.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idle_len_q <= i_idle_len;
            r_data_len_q <= '0;
            r_block      <= BLOCK_IDLE;
            r_valid      <= 1'b0;
            r_frame_cnt  <= '0;
        end else if (i_enable) begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_idle_len_q <= w_idle_len_next;
            r_data_len_q <= w_data_len_next;
            r_block      <= w_block_next;
            r_valid      <= 1'b1;
            r_frame_cnt  <= w_frame_cnt_next;
        end else begin
            r_valid      <= 1'b0;
        end
    end

    // The generator advances on the same edge that samples its current word.
    assign bus.o_data_req  = i_reset & i_enable & (r_state == S_DATA);
    assign bus.o_block     = r_block;
    assign bus.o_valid     = r_valid;
    assign bus.o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_frame_builder.sv
// Randomized scoreboard bench for frame_builder: a token-queue frame planner
// predicts the stream, a monitor compares every presented block.
module tb_frame_builder;
    localparam int CW = 4;

    typedef enum {T_IDLE, T_START, T_DATA, T_TERM} tok_t;
    typedef struct {
        logic [65:0]   blk;
        logic [CW-1:0] cnt;
    } exp_t;

    localparam logic [65:0] E_IDLE  = {2'b10, 64'h1E00_0000_0000_0000};
    localparam logic [65:0] E_START = {2'b10, 64'h7855_5555_5555_55D5};
    localparam logic [65:0] E_TERM  = {2'b10, 64'h8700_0000_0000_0000};

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_enable = 1'b0;
    logic [15:0] i_data_len = '0;
    logic [15:0] i_idle_len = '0;

    frame_builder_if #(.DATA_BLOCK_LEN(64), .SYNC_LEN(2), .FRAME_CNT_WIDTH(CW)) bus ();

    frame_builder #(
        .DATA_BLOCK_LEN (64),
        .SYNC_LEN       (2),
        .LEN_WIDTH      (16),
        .FRAME_CNT_WIDTH(CW)
    ) dut (
        .i_clock   (clk),
        .i_reset   (i_reset),
        .i_enable  (i_enable),
        .i_data_len(i_data_len),
        .i_idle_len(i_idle_len),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Data generator: a table of random words, stepping on each request.
    logic [63:0] words [256];
    logic [7:0]  gen_idx = '0;
    assign bus.i_data_block = words[gen_idx];
    always @(posedge clk) if (bus.o_data_req) gen_idx <= gen_idx + 8'd1;

    logic rst_seen = 1'b0;
    always @(posedge clk) rst_seen <= ~i_reset;

    // Reference model state
    tok_t          plan[$];
    exp_t          sb[$];
    logic [7:0]    m_idx = '0;
    logic [CW-1:0] m_cnt = '0;
    logic          exp_req = 1'b0;
    bit            done = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic step(input bit rst, input bit en, input logic [15:0] dl, input logic [15:0] il);
        tok_t tok;
        exp_t e;
        @(posedge clk);
        #1;
        i_reset    = ~rst;
        i_enable   = en;
        i_data_len = dl;
        i_idle_len = il;
        exp_req    = 1'b0;
        if (rst) begin
            plan.delete();
            repeat ((il == 0) ? 1 : int'(il)) plan.push_back(T_IDLE);
            m_cnt = '0;
        end else if (en) begin
            if (plan.size() == 0) begin
                plan.push_back(T_START);
                repeat (int'(dl)) plan.push_back(T_DATA);
                plan.push_back(T_TERM);
            end
            tok = plan.pop_front();
            case (tok)
                T_IDLE:  e.blk = E_IDLE;
                T_START: e.blk = E_START;
                T_DATA: begin
                    e.blk   = {2'b01, words[m_idx]};
                    m_idx   = m_idx + 8'd1;
                    exp_req = 1'b1;
                end
                default: begin
                    e.blk = E_TERM;
                    m_cnt = m_cnt + 1'b1;
                    repeat (int'(il)) plan.push_back(T_IDLE);
                end
            endcase
            e.cnt = m_cnt;
            sb.push_back(e);
        end
    endtask

    task automatic check(input string nm, input logic [65:0] got, input logic [65:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Monitor: owns all comparisons and the summary.
    initial begin : monitor
        bit          armed;
        exp_t        e;
        logic [65:0] last_blk;
        logic [CW-1:0] last_cnt;
        armed    = 1'b0;
        last_blk = '0;
        last_cnt = '0;
        forever begin
            @(negedge clk);
            if (done) begin
                check("scoreboard_drained", 66'(sb.size()), 66'(0));
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
            if (!armed && rst_seen) armed = 1'b1;
            if (armed) begin
                check("data_req", 66'(bus.o_data_req), 66'(exp_req));
                if (rst_seen) begin
                    check("rst_block", bus.o_block, E_IDLE);
                    check("rst_valid", 66'(bus.o_valid), 66'(0));
                    check("rst_frame_cnt", 66'(bus.o_frame_cnt), 66'(0));
                end else if (bus.o_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 66'(1), 66'(0));
                    end else begin
                        e = sb.pop_front();
                        $display("blk %h cnt %0d", bus.o_block, bus.o_frame_cnt);
                        check("block", bus.o_block, e.blk);
                        check("frame_cnt", 66'(bus.o_frame_cnt), 66'(e.cnt));
                    end
                end else begin
                    check("hold_block", bus.o_block, last_blk);
                    check("hold_frame_cnt", 66'(bus.o_frame_cnt), 66'(last_cnt));
                end
                last_blk = bus.o_block;
                last_cnt = bus.o_frame_cnt;
            end
        end
    end

    initial begin : stimulus
        logic [15:0] dl, il;
        for (int i = 0; i < 256; i++) words[i] = {$urandom, $urandom};

        // Basic frame: idle 2, data 3
        repeat (2) step(1, 0, 16'd3, 16'd2);
        repeat (30) step(0, 1, 16'd3, 16'd2);

        // Zero lengths, long enough to wrap the 4-bit frame counter
        step(1, 0, 16'd0, 16'd0);
        repeat (40) step(0, 1, 16'd0, 16'd0);

        // Mid-frame data length change 4 -> 1
        step(1, 0, 16'd4, 16'd1);
        for (int i = 0; i < 30; i++) step(0, 1, (i < 6) ? 16'd4 : 16'd1, 16'd1);

        // Enable gaps during the data phase
        step(1, 0, 16'd6, 16'd1);
        for (int i = 0; i < 40; i++) step(0, (i >= 3 && i < 11) ? bit'(i % 2) : 1'b1, 16'd6, 16'd1);

        // Mid-frame reset in S_DATA
        step(1, 0, 16'd8, 16'd1);
        repeat (5) step(0, 1, 16'd8, 16'd1);
        step(1, 1, 16'd8, 16'd1);
        repeat (15) step(0, 1, 16'd8, 16'd1);

        // Random traffic
        dl = 16'd3;
        il = 16'd2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) dl = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 7) == 0) il = 16'($urandom_range(0, 3));
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), dl, il);
        end

        @(posedge clk);
        #1;
        i_enable = 1'b0;
        exp_req  = 1'b0;
        repeat (2) @(negedge clk);
        done = 1'b1;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
